msx_mouse_encoder: RTL and testbench

//  Parametrised MSX mouse protocol encoder for one joystick port; one instance per port.

---
 rtl/msx_mouse_encoder.sv | 168 ++++++++++++++++
 tb/tb_msx_mouse_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/msx_mouse_encoder.sv
// MSX mouse protocol encoder for a single joystick port.
// Accumulates host mouse deltas with saturation and serves them as four nibbles
// (Xhi, Xlo, Yhi, Ylo) on STR toggles, resyncing to Xhi after an idle timeout.
module msx_mouse_encoder #(
  parameter int unsigned TIMEOUT     = 100000,
  parameter bit          INVERT_X    = 1'b1,
  parameter bit          INVERT_Y    = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk_sys,
  input  logic       i_reset,
  input  logic [8:0] i_mouse_x,
  input  logic [8:0] i_mouse_y,
  input  logic [7:0] i_mouse_flags,
  input  logic       i_mouse_strobe,
  input  logic [5:0] i_joy_n,
  input  logic       i_str,
  output logic       o_mouse_en,
  output logic [5:0] o_pin_out,
  output logic [1:0] o_nib_state
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StXhi = 2'd0, StXlo = 2'd1, StYhi = 2'd2, StYlo = 2'd3} nib_e;

  // Sign-extend to 10 bits; negating -256 yields +256, which fits and later clamps.
  function automatic logic signed [9:0] f_delta(input logic [8:0] v, input bit inv);
    logic signed [9:0] s;
    s = $signed({v[8], v});
    return inv ? -s : s;
  endfunction

  function automatic logic [7:0] f_sat(input logic [7:0] acc, input logic signed [9:0] d);
    logic signed [10:0] s;
    s = $signed({{3{acc[7]}}, acc}) + $signed({d[9], d});
    if (s > 11'sd127) begin
      return 8'h7F;
    end else if (s < -11'sd128) begin
      return 8'h80;
    end else begin
      return s[7:0];
    end
  endfunction

  logic [SYNC_STAGES-1:0] r_str_sync;
  logic                   r_str_prev;
  logic                   r_mouse_en;
  logic [7:0]             r_acc_x, r_acc_y;
  logic [7:0]             r_sx, r_sy;
  logic [TW-1:0]          r_tmo;
  nib_e                   r_state;
  logic [5:0]             r_pin_out;

  logic                   w_sync_out;
  logic                   w_edge;
  logic                   w_take;
  logic                   w_snap;
  logic signed [9:0]      w_dx, w_dy;
  logic [7:0]             w_base_x, w_base_y;

  assign w_sync_out = r_str_sync[SYNC_STAGES-1];
  assign w_edge     = w_sync_out ^ r_str_prev;
  assign w_take     = w_edge & r_mouse_en;
  assign w_snap     = w_take & (r_state == StXhi);
  assign w_dx       = f_delta(i_mouse_x, INVERT_X);
  assign w_dy       = f_delta(i_mouse_y, INVERT_Y);
  // A snapshot in the same cycle takes the old value, so the strobe starts from zero.
  assign w_base_x   = (!r_mouse_en || w_snap) ? 8'h00 : r_acc_x;
  assign w_base_y   = (!r_mouse_en || w_snap) ? 8'h00 : r_acc_y;

  assign o_mouse_en  = r_mouse_en;
  assign o_pin_out   = r_pin_out;
  assign o_nib_state = r_state;

  // STR synchroniser chain plus the compare flop used for edge detection.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_str_sync <= '0;
      r_str_prev <= 1'b0;
    end else begin
      r_str_sync[0] <= i_str;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_str_sync[i] <= r_str_sync[i-1];
      end
      r_str_prev <= w_sync_out;
    end
  end

  // Port ownership: mouse traffic claims the port, joystick activity releases it.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_mouse_en <= 1'b0;
    end else if (i_mouse_strobe) begin
      r_mouse_en <= 1'b1;
    end else if (!(&i_joy_n)) begin
      r_mouse_en <= 1'b0;
    end
  end

  // Delta accumulators, cleared on snapshot and held at zero while disabled.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_acc_x <= 8'h00;
      r_acc_y <= 8'h00;
    end else if (i_mouse_strobe) begin
      r_acc_x <= f_sat(w_base_x, w_dx);
      r_acc_y <= f_sat(w_base_y, w_dy);
    end else if (!r_mouse_en || w_snap) begin
      r_acc_x <= 8'h00;
      r_acc_y <= 8'h00;
    end
  end

  // Snapshot of both axes at the start of each four-nibble read.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_sx <= 8'h00;
      r_sy <= 8'h00;
    end else if (w_snap) begin
      r_sx <= r_acc_x;
      r_sy <= r_acc_y;
    end
  end

  // Nibble sequencer, timeout resync and registered pin levels.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state   <= StXhi;
      r_tmo     <= '0;
      r_pin_out <= 6'h3F;
    end else if (!r_mouse_en) begin
      r_state   <= StXhi;
      r_tmo     <= '0;
      r_pin_out <= 6'h3F;
    end else begin
      r_pin_out[5:4] <= ~i_mouse_flags[1:0];
      if (w_edge) begin
        r_tmo <= TW'(TIMEOUT);
        unique case (r_state)
          StXhi: begin
            r_pin_out[3:0] <= r_acc_x[7:4];
            r_state        <= StXlo;
          end
          StXlo: begin
            r_pin_out[3:0] <= r_sx[3:0];
            r_state        <= StYhi;
          end
          StYhi: begin
            r_pin_out[3:0] <= r_sy[7:4];
            r_state        <= StYlo;
          end
          StYlo: begin
            r_pin_out[3:0] <= r_sy[3:0];
            r_state        <= StXhi;
          end
          default: r_state <= StXhi;
        endcase
      end else if (r_tmo != '0) begin
        r_tmo <= r_tmo - 1'b1;
        if (r_tmo == TW'(1)) begin
          r_state <= StXhi;
        end
      end
    end
  end

endmodule

// File: tb/tb_msx_mouse_encoder.sv
// Directed bench for msx_mouse_encoder with hand-computed nibble sequences.
module tb_msx_mouse_encoder;

  localparam int unsigned TMO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] mouse_x, mouse_y;
  logic [7:0] mouse_flags;
  logic       mouse_strobe;
  logic [5:0] joy_n;
  logic       str;
  logic       mouse_en;
  logic [5:0] pin_out;
  logic [1:0] nib_state;

  int total = 0;
  int bad   = 0;

  msx_mouse_encoder #(
    .TIMEOUT    (TMO),
    .INVERT_X   (1'b1),
    .INVERT_Y   (1'b0),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk_sys     (clk),
    .i_reset       (reset),
    .i_mouse_x     (mouse_x),
    .i_mouse_y     (mouse_y),
    .i_mouse_flags (mouse_flags),
    .i_mouse_strobe(mouse_strobe),
    .i_joy_n       (joy_n),
    .i_str         (str),
    .o_mouse_en    (mouse_en),
    .o_pin_out     (pin_out),
    .o_nib_state   (nib_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [8:0] x, input logic [8:0] y);
    mouse_x      = x;
    mouse_y      = y;
    mouse_strobe = 1'b1;
    tick();
    mouse_strobe = 1'b0;
  endtask

  // Toggle STR and check the nibble once it has crossed sync, edge and output flops.
  task automatic rd(input string tag, input logic [3:0] nib, input logic [1:0] st);
    str = ~str;
    repeat (3) tick();
    chk({tag, "_nib"}, {4'h0, pin_out[3:0]}, {4'h0, nib});
    chk({tag, "_st"}, {6'h0, nib_state}, {6'h0, st});
  endtask

  initial begin
    reset        = 1'b1;
    mouse_x      = '0;
    mouse_y      = '0;
    mouse_flags  = '0;
    mouse_strobe = 1'b0;
    joy_n        = 6'h3F;
    str          = 1'b0;
    tick();
    reset = 1'b0;
    // 1: reset values
    chk("rst_en", {7'h0, mouse_en}, 8'h00);
    chk("rst_pin", {2'b0, pin_out}, 8'h3F);
    chk("rst_st", {6'h0, nib_state}, 8'h00);
    tick();

    // 2: x=+5 (inverted -> FB), y=-3 (FD)
    strobe(9'd5, 9'h1FD);
    chk("t2_en", {7'h0, mouse_en}, 8'h01);
    tick();
    chk("t2_pin_idle", {2'b0, pin_out}, 8'h3F);
    rd("t2_xhi", 4'hF, 2'd1);
    rd("t2_xlo", 4'hB, 2'd2);
    rd("t2_yhi", 4'hF, 2'd3);
    mouse_flags = 8'h01;
    rd("t2_ylo", 4'hD, 2'd0);
    chk("t2_btn", {2'b0, pin_out}, 8'h2D);
    mouse_flags = 8'h00;

    // 3: three strobes of x=-100 saturate at +127
    strobe(9'h19C, 9'd0);
    strobe(9'h19C, 9'd0);
    strobe(9'h19C, 9'd0);
    rd("t3_xhi", 4'h7, 2'd1);
    rd("t3_xlo", 4'hF, 2'd2);
    rd("t3_yhi", 4'h0, 2'd3);
    rd("t3_ylo", 4'h0, 2'd0);
    rd("t3_xhi2", 4'h0, 2'd1);
    rd("t3_xlo2", 4'h0, 2'd2);

    // 4: idle timeout resyncs to Xhi; x=-48 accumulates +0x30
    strobe(9'h1D0, 9'd0);
    repeat (10) tick();
    chk("t4_hold", {6'h0, nib_state}, 8'h02);
    repeat (TMO) tick();
    chk("t4_tmo", {6'h0, nib_state}, 8'h00);
    rd("t4_xhi", 4'h3, 2'd1);
    rd("t4_xlo", 4'h0, 2'd2);
    rd("t4_yhi", 4'h0, 2'd3);
    rd("t4_ylo", 4'h0, 2'd0);

    // 5: joystick activity yields the port; a strobe reclaims it (x=+2 -> acc -2)
    joy_n = 6'b111110;
    tick();
    tick();
    joy_n = 6'h3F;
    chk("t5_en", {7'h0, mouse_en}, 8'h00);
    chk("t5_pin", {2'b0, pin_out}, 8'h3F);
    chk("t5_st", {6'h0, nib_state}, 8'h00);
    strobe(9'd2, 9'd0);
    chk("t5_reen", {7'h0, mouse_en}, 8'h01);

    // 6: strobe x=+1 coincident with the S0 edge
    str = ~str;
    tick();
    tick();
    mouse_x      = 9'd1;
    mouse_y      = 9'd0;
    mouse_strobe = 1'b1;
    tick();
    mouse_strobe = 1'b0;
    chk("t6_xhi_nib", {4'h0, pin_out[3:0]}, 8'h0F);
    chk("t6_xhi_st", {6'h0, nib_state}, 8'h01);
    rd("t6_xlo", 4'hE, 2'd2);
    rd("t6_yhi", 4'h0, 2'd3);
    rd("t6_ylo", 4'h0, 2'd0);
    rd("t6_xhi2", 4'hF, 2'd1);
    rd("t6_xlo2", 4'hF, 2'd2);

    // Reset mid-sequence
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_en", {7'h0, mouse_en}, 8'h00);
    chk("mid_rst_pin", {2'b0, pin_out}, 8'h3F);
    chk("mid_rst_st", {6'h0, nib_state}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
